spi_burst_ram: RTL and testbench
================================

# spi_burst_ram

Burst-addressed register RAM sitting directly downstream of `spi_slave`, replacing the loopback FIFO in SPI test tops. It consumes the slave's decoded `ctrl`/`address`, stores write-burst bytes at auto-incrementing addresses, and serves read-burst bytes from the same RAM on the slave's `tx_en`/`tx_valid`/`tx_data` handshake. Host software can therefore write a block over CH347 SPI and read it back at any address.

## Interface
- `CTRL_WIDTH`, 8, width of `ctrl`
- `ADDR_WIDTH`, 8, width of `address`; RAM depth is 2**ADDR_WIDTH words
- `DATA_WIDTH`, 8, word width
- `CTRL_WRITE`, 8'h3a, write command code
- `CTRL_READ`, 8'h3b, read command code
- `clock`  in  1  single system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `ctrl`  in  CTRL_WIDTH  command byte from `spi_slave`; stable for the whole transaction
- `address`  in  ADDR_WIDTH  start address from `spi_slave`; stable for the whole transaction
- `rx_en`  in  1  one-cycle strobe: `rx_data` valid
- `rx_data`  in  DATA_WIDTH  received byte
- `tx_en`  in  1  one-cycle request for the next read byte
- `tx_valid`  out  1  one-cycle strobe: `tx_data` valid
- `tx_data`  out  DATA_WIDTH  read byte; held between strobes
- `spi_done`  in  1  one-cycle end-of-transaction pulse
- `busy`  out  1  state is not IDLE
- `wr_count`  out  16  beats written in the current or last write burst
- `rd_count`  out  16  beats read in the current or last read burst
- `ctrl_err`  out  1  sticky flag: a beat arrived with an unmatched command
- `ovf`  out  1  sticky flag: a beat was dropped at the top of RAM (only when wrapping is compiled out)

## Operation
- States: IDLE, WRITE, READ.
- IDLE, `rx_en`=1 and `ctrl`==CTRL_WRITE:
  - write `mem[address]`
  - `ptr`<=`address`+1, `wr_count`<=1
  - go to WRITE
- IDLE, `tx_en`=1 and `ctrl`==CTRL_READ:
  - `tx_data`<=`mem[address]`, `tx_valid` pulses
  - `ptr`<=`address`+1, `rd_count`<=1
  - go to READ
- IDLE, beat with any other `ctrl`, or a mismatched strobe (e.g. `rx_en` with CTRL_READ):
  - beat ignored
  - `ctrl_err`<=1
  - stay in IDLE
- WRITE: each `rx_en` writes `mem[ptr]`, then `ptr`++ and `wr_count`++. `tx_en` is ignored.
- READ: each `tx_en` loads `tx_data`<=`mem[ptr]` and pulses `tx_valid`, then `ptr`++ and `rd_count`++. `rx_en` is ignored.
- `spi_done` in any state moves to IDLE on the next cycle. A beat in the same cycle as `spi_done` is still processed.
- `rx_en` and `tx_en` together in IDLE: `rx_en` has priority.
- Counters saturate at 16'hFFFF. Each counter is cleared only at the start of its own burst type.
- `ptr` is ADDR_WIDTH bits. For wrap behaviour, see Configuration.
- Reset (low):
  - state IDLE, `ptr`=0
  - `tx_valid`=0, `tx_data`=0
  - `wr_count`=0, `rd_count`=0
  - `ctrl_err`=0, `ovf`=0
  - `busy`=0
  - RAM contents are not cleared
- Reset mid-burst aborts the burst; the next beat is treated as an IDLE beat.
- `ctrl_err` and `ovf` clear only on reset.

## Timing
- Write: a word written on the `rx_en` edge is readable by a `tx_en` on the following cycle.
- Read latency: `tx_valid` is asserted exactly 1 cycle after `tx_en`, with `tx_data` registered alongside it.
- Back-to-back `tx_en` on consecutive cycles is supported at full rate, giving consecutive addresses.
- `busy` rises the cycle after the first accepted beat and falls the cycle after `spi_done`.
- RAM is a single-port synchronous array, inferable as distributed or block RAM.

## Configuration
- Macro: `SPI_BURST_RAM_WRAP_EN`.
- Defined: `ptr` wraps from 2**ADDR_WIDTH-1 to 0, and bursts continue across the boundary. `ovf` is tied to 0.
- Undefined: once `ptr` has passed the last address, further write beats are dropped and read beats return all-zero `tx_data` (`tx_valid` still pulses). Each dropped beat sets `ovf`. Counters still increment.

## Test plan
- Reset low 3 cycles: all outputs zero, `busy`=0.
- Write burst `ctrl`=3a, `address`=0x10, 8 bytes 0x01..0x08, then `spi_done`:
  - `wr_count`=8, `busy` falls
  - read burst `ctrl`=3b, `address`=0x10, 8 `tx_en` gives `tx_data` 0x01..0x08, each 1 cycle after its `tx_en`, `rd_count`=8
- Read `address`=0x14 with 2 back-to-back `tx_en`: `tx_data` 0x05 then 0x06 on consecutive cycles.
- `ctrl`=0x55 with `rx_en`: no write (read back at `address` unchanged), `ctrl_err`=1, state stays IDLE.
- Write at `address`=0xFE with bytes AA, BB, CC:
  - WRAP_EN defined: `mem[0]`=CC, `ovf`=0
  - WRAP_EN undefined: `mem[0]` unchanged, `ovf`=1
- Reset mid-write after 2 of 4 beats: state IDLE, `wr_count`=0, the 2 written bytes are kept; the next `rx_en` with `ctrl`=3a writes at `address`.

Source files
------------

// File: rtl/spi_burst_ram.sv
// spi_burst_ram: burst-addressed register RAM behind spi_slave.
// Write bursts store rx bytes at auto-incrementing addresses starting at
// `address`. Read bursts return bytes on the tx_en/tx_valid/tx_data handshake.
//
// Ports:
//   clock, reset        system clock, synchronous active-low reset
//   ctrl, address       command byte and start address, stable per transaction
//   rx_en, rx_data      write beat strobe and byte
//   tx_en               read beat request
//   tx_valid, tx_data   read byte strobe (1 cycle after tx_en) and held byte
//   spi_done            end-of-transaction pulse
//   busy                state is not IDLE
//   wr_count, rd_count  saturating beat counters of the current/last burst
//   ctrl_err            sticky: beat with an unmatched command in IDLE
//   ovf                 sticky: beat past the top of RAM (no-wrap build only)
//
// Build option: define SPI_BURST_RAM_WRAP_EN to let the burst pointer wrap
// from the top address to 0. Without it, beats past the top are dropped
// (writes discarded, reads return zero) and flagged on ovf.
module spi_burst_ram #(
  parameter int CTRL_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter logic [CTRL_WIDTH-1:0] CTRL_WRITE = 8'h3a,
  parameter logic [CTRL_WIDTH-1:0] CTRL_READ  = 8'h3b
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [CTRL_WIDTH-1:0] ctrl,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  rx_en,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  tx_en,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  spi_done,
  output logic                  busy,
  output logic [15:0]           wr_count,
  output logic [15:0]           rd_count,
  output logic                  ctrl_err,
  output logic                  ovf
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic                  r_tx_valid;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_busy;
  logic [15:0]           r_wr_count;
  logic [15:0]           r_rd_count;
  logic                  r_ctrl_err;
  logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];

  logic                  w_idle;
  logic                  w_start_wr;
  logic                  w_start_rd;
  logic                  w_bad_beat;
  logic                  w_burst_wr;
  logic                  w_burst_rd;
  logic                  w_drop;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_rd_word;

  assign w_idle     = (r_state == S_IDLE);
  // rx_en wins over tx_en in IDLE, so a read start needs rx_en low.
  assign w_start_wr = w_idle && rx_en && (ctrl == CTRL_WRITE);
  assign w_start_rd = w_idle && !rx_en && tx_en && (ctrl == CTRL_READ);
  assign w_bad_beat = w_idle && (rx_en ? (ctrl != CTRL_WRITE)
                                       : (tx_en && (ctrl != CTRL_READ)));
  assign w_burst_wr = (r_state == S_WRITE) && rx_en;
  assign w_burst_rd = (r_state == S_READ) && tx_en;

  // Single port: the start beat uses the slave's address, later beats ptr.
  assign w_addr    = w_idle ? address : r_ptr;
  assign w_rd_word = r_mem[w_addr];
  assign w_mem_we  = w_start_wr || (w_burst_wr && !w_drop);

`ifdef SPI_BURST_RAM_WRAP_EN
  assign w_drop = 1'b0;
  assign ovf    = 1'b0;
`else
  // Set once ptr has stepped past the last address; ptr itself has wrapped
  // to 0 by then, so this flag is what marks the rest of the burst as dead.
  logic r_past_end;
  logic r_ovf;
  assign w_drop = (w_burst_wr || w_burst_rd) && r_past_end;
  assign ovf    = r_ovf;
`endif

  always_ff @(posedge clock) begin
    if (w_mem_we) r_mem[w_addr] <= rx_data;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_busy     <= 1'b0;
      r_wr_count <= '0;
      r_rd_count <= '0;
      r_ctrl_err <= 1'b0;
`ifndef SPI_BURST_RAM_WRAP_EN
      r_past_end <= 1'b0;
      r_ovf      <= 1'b0;
`endif
    end else begin
      r_tx_valid <= 1'b0;
      r_busy     <= !spi_done && (w_start_wr || w_start_rd || !w_idle);

      if (w_start_wr || w_start_rd) begin
        r_ptr <= address + 1'b1;
`ifndef SPI_BURST_RAM_WRAP_EN
        r_past_end <= &address;
`endif
        if (w_start_wr) begin
          r_wr_count <= 16'd1;
          r_state    <= S_WRITE;
        end else begin
          r_rd_count <= 16'd1;
          r_tx_data  <= w_rd_word;
          r_tx_valid <= 1'b1;
          r_state    <= S_READ;
        end
      end

      if (w_bad_beat) r_ctrl_err <= 1'b1;

      if (w_burst_wr || w_burst_rd) begin
        r_ptr <= r_ptr + 1'b1;
`ifndef SPI_BURST_RAM_WRAP_EN
        if (&r_ptr) r_past_end <= 1'b1;
        if (w_drop) r_ovf <= 1'b1;
`endif
        if (w_burst_wr) begin
          if (r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 16'd1;
        end else begin
          if (r_rd_count != 16'hFFFF) r_rd_count <= r_rd_count + 16'd1;
          r_tx_data  <= w_drop ? '0 : w_rd_word;
          r_tx_valid <= 1'b1;
        end
      end

      // A beat in the same cycle is still taken above; spi_done only ends it.
      if (spi_done) r_state <= S_IDLE;
    end
  end

  assign tx_valid = r_tx_valid;
  assign tx_data  = r_tx_data;
  assign busy     = r_busy;
  assign wr_count = r_wr_count;
  assign rd_count = r_rd_count;
  assign ctrl_err = r_ctrl_err;

endmodule

// File: tb/tb_spi_burst_ram.sv
module tb_spi_burst_ram;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] ctrl;
  logic [7:0] address;
  logic       rx_en;
  logic [7:0] rx_data;
  logic       tx_en;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       spi_done;
  logic       busy;
  logic [15:0] wr_count;
  logic [15:0] rd_count;
  logic       ctrl_err;
  logic       ovf;

  spi_burst_ram dut (
    .clock(clock), .reset(reset), .ctrl(ctrl), .address(address),
    .rx_en(rx_en), .rx_data(rx_data), .tx_en(tx_en),
    .tx_valid(tx_valid), .tx_data(tx_data), .spi_done(spi_done),
    .busy(busy), .wr_count(wr_count), .rd_count(rd_count),
    .ctrl_err(ctrl_err), .ovf(ovf)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: unbounded integer pointer, plain byte array.
  localparam int DEPTH = 256;
  logic [7:0] m_mem [DEPTH];
  int  m_mode = 0;           // 0 idle, 1 writing, 2 reading
  int  m_ptr  = 0;
  int  m_wr = 0, m_rd = 0;
  bit  m_err = 0, m_ovf = 0, m_txv = 0;
  logic [7:0] m_txd = 0;

  function automatic bit in_range(int p);
`ifdef SPI_BURST_RAM_WRAP_EN
    return 1'b1;
`else
    return p < DEPTH;
`endif
  endfunction

  always @(posedge clock) begin
    int nmode;
    if (!reset) begin
      m_mode = 0; m_wr = 0; m_rd = 0; m_err = 0; m_ovf = 0; m_txv = 0; m_txd = 0;
    end else begin
      nmode = m_mode;
      m_txv = 0;
      if (m_mode == 0) begin
        if (rx_en) begin
          if (ctrl == 8'h3a) begin
            m_mem[address] = rx_data; m_ptr = int'(address) + 1; m_wr = 1; nmode = 1;
          end else m_err = 1;
        end else if (tx_en) begin
          if (ctrl == 8'h3b) begin
            m_txd = m_mem[address]; m_txv = 1; m_ptr = int'(address) + 1; m_rd = 1; nmode = 2;
          end else m_err = 1;
        end
      end else if (m_mode == 1 && rx_en) begin
        if (in_range(m_ptr)) m_mem[m_ptr % DEPTH] = rx_data;
        else m_ovf = 1;
        m_ptr++;
        if (m_wr < 65535) m_wr++;
      end else if (m_mode == 2 && tx_en) begin
        if (in_range(m_ptr)) m_txd = m_mem[m_ptr % DEPTH];
        else begin m_txd = 0; m_ovf = 1; end
        m_txv = 1;
        m_ptr++;
        if (m_rd < 65535) m_rd++;
      end
      if (spi_done) nmode = 0;
      m_mode = nmode;
    end
  end

  bit chk_en = 0;
  logic [7:0] capq [$];

  always @(negedge clock) begin
    if (chk_en) begin
      chk("busy", int'(busy), int'(m_mode != 0));
      chk("wr_count", int'(wr_count), m_wr);
      chk("rd_count", int'(rd_count), m_rd);
      chk("ctrl_err", int'(ctrl_err), int'(m_err));
      chk("ovf", int'(ovf), int'(m_ovf));
      chk("tx_valid", int'(tx_valid), int'(m_txv));
      chk("tx_data", int'(tx_data), int'(m_txd));
      if (tx_valid) capq.push_back(tx_data);
    end
  end

  task automatic drive(input bit rx, input bit tx, input bit done, input logic [7:0] d);
    @(negedge clock);
    rx_en = rx; tx_en = tx; spi_done = done; rx_data = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 8'h00);
  endtask

  task automatic read_burst(input logic [7:0] a, input int n);
    ctrl = 8'h3b; address = a;
    capq.delete();
    for (int i = 0; i < n; i++) drive(0, 1, 0, 8'h00);
    drive(0, 0, 1, 8'h00);
    idle(2);
  endtask

  task automatic chk_cap(input string name, input int idx, input int exp);
    if (idx < capq.size()) chk(name, int'(capq[idx]), exp);
    else chk({name, "_missing"}, capq.size(), idx + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 0; ctrl = 0; address = 0; rx_en = 0; rx_data = 0; tx_en = 0; spi_done = 0;
    @(posedge clock); #1 chk_en = 1;
    repeat (3) @(negedge clock);
    chk("rst_busy", int'(busy), 0);
    chk("rst_wr_count", int'(wr_count), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    reset = 1;
    idle(1);

    // Preload every address with i ^ 5A.
    ctrl = 8'h3a; address = 8'h00;
    for (int i = 0; i < DEPTH; i++) drive(1, 0, 0, 8'(i) ^ 8'h5a);
    drive(0, 0, 1, 8'h00);
    idle(2);
    chk("preload_ovf", int'(ovf), 0);

    // Write 01..08 at 0x10, then read it back.
    ctrl = 8'h3a; address = 8'h10;
    for (int i = 1; i <= 8; i++) drive(1, 0, 0, 8'(i));
    drive(0, 0, 1, 8'h00);
    idle(2);
    chk("wr8_count", int'(wr_count), 8);
    chk("wr8_busy", int'(busy), 0);
    read_burst(8'h10, 8);
    chk("rd8_count", int'(rd_count), 8);
    chk("rd8_len", capq.size(), 8);
    for (int i = 0; i < 8; i++) chk_cap("rd8_data", i, i + 1);

    read_burst(8'h14, 2);
    chk_cap("b2b_0", 0, 8'h05);
    chk_cap("b2b_1", 1, 8'h06);

    // Unknown command: no write, sticky error.
    ctrl = 8'h55; address = 8'h20;
    drive(1, 0, 0, 8'hee);
    idle(2);
    chk("bad_ctrl_err", int'(ctrl_err), 1);
    chk("bad_busy", int'(busy), 0);
    read_burst(8'h20, 1);
    chk_cap("bad_nowrite", 0, 8'h7a);

    // rx_en and tx_en together in IDLE: write wins.
    ctrl = 8'h3a; address = 8'h40;
    drive(1, 1, 1, 8'h77);
    idle(2);
    read_burst(8'h40, 1);
    chk_cap("prio_rx", 0, 8'h77);

    // Top-of-RAM write, spi_done coincident with the last beat.
    ctrl = 8'h3a; address = 8'hfe;
    drive(1, 0, 0, 8'haa);
    drive(1, 0, 0, 8'hbb);
    drive(1, 0, 1, 8'hcc);
    idle(2);
    chk("top_wr_count", int'(wr_count), 3);
    read_burst(8'h00, 1);
    read_burst(8'hfe, 3);
    chk_cap("top_fe", 0, 8'haa);
    chk_cap("top_ff", 1, 8'hbb);
`ifdef SPI_BURST_RAM_WRAP_EN
    chk_cap("top_wrap", 2, 8'hcc);
    chk("top_ovf", int'(ovf), 0);
`else
    chk_cap("top_nowrap", 2, 8'h00);
    chk("top_ovf", int'(ovf), 1);
`endif

    // Reset after 2 of 4 beats.
    ctrl = 8'h3a; address = 8'h30;
    drive(1, 0, 0, 8'h11);
    drive(1, 0, 0, 8'h22);
    drive(0, 0, 0, 8'h00);
    reset = 0;
    idle(2);
    reset = 1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_wr_count", int'(wr_count), 0);
    chk("midrst_err", int'(ctrl_err), 0);
    drive(1, 0, 0, 8'h99);
    drive(0, 0, 1, 8'h00);
    idle(2);
    read_burst(8'h30, 3);
    chk_cap("midrst_30", 0, 8'h99);
    chk_cap("midrst_31", 1, 8'h22);
    chk_cap("midrst_32", 2, 8'h68);

    idle(2);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
